// File: rtl/row_memory_responder.sv
// row_memory_responder
// Word-addressed 16-bit memory behind a level-request handshake. One request
// is serviced at a time. Refresh has the highest priority, then write, then read.
// A read or write passes through a programmable wait and then one acknowledge
// cycle. A watchdog flags refresh starvation.
module row_memory_responder #(
  parameter int ADDR_W         = 24,
  parameter int DEPTH          = 32768,
  parameter int ACK_LATENCY    = 2,
  parameter int REFRESH_CYCLES = 8,
  parameter int REFRESH_LIMIT  = 1040
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] readAddress,
  output logic              readAcknowledge,
  output logic [15:0]       readData,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [15:0]       writeData,
  output logic              writeAcknowledge,
  input  logic              refresh,
  output logic              refreshAcknowledge,
  output logic              busy,
  output logic              refreshMissed
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W  = 4;
  localparam int RCNT_W = 8;
  localparam int TMR_W  = $clog2(REFRESH_LIMIT + 1);

  // Addresses are compared one bit wider so that DEPTH itself is representable.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(ACK_LATENCY - 1);
  localparam logic [RCNT_W-1:0] REF_LAST  = RCNT_W'(REFRESH_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(REFRESH_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_REFRESH = 2'd3
  } state_t;

  // With zero latency an accepted access goes straight to its acknowledge.
  localparam state_t S_AFTER_ACCEPT = (ACK_LATENCY == 0) ? S_ACK : S_WAIT;

  state_t              state_q, state_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                missed_q, missed_d;
  logic                rd_ack_q, rd_ack_d;
  logic                wr_ack_q, wr_ack_d;
  logic                ref_ack_q, ref_ack_d;
  logic                busy_q, busy_d;
  logic [15:0]         rdata_q;

  logic                in_range_d_s;
  logic                in_range_q_s;
  logic [IDX_W-1:0]    idx_d_s;
  logic [IDX_W-1:0]    idx_q_s;
  logic                mem_we_s;

  // Storage array: no reset, so it maps onto block RAM.
  logic [15:0]         mem_q [DEPTH];

  // Next-state logic: arbitrate in IDLE, count wait and refresh cycles elsewhere.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lat_d   = lat_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_IDLE: begin
        lat_d  = {LAT_W{1'b0}};
        rcnt_d = {RCNT_W{1'b0}};
        if (refresh) begin
          state_d = S_REFRESH;
        end else if (write) begin
          state_d = S_AFTER_ACCEPT;
          op_wr_d = 1'b1;
          addr_d  = writeAddress;
          wdata_d = writeData;
        end else if (read) begin
          state_d = S_AFTER_ACCEPT;
          op_wr_d = 1'b0;
          addr_d  = readAddress;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_ACK;
          lat_d   = {LAT_W{1'b0}};
        end else begin
          lat_d   = lat_q + 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      S_REFRESH: begin
        if (rcnt_q == REF_LAST) begin
          state_d = S_IDLE;
          rcnt_d  = {RCNT_W{1'b0}};
        end else begin
          rcnt_d  = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address decode for the access being set up and for the captured access.
  always_comb begin
    in_range_d_s = ({1'b0, addr_d} < DEPTH_EXT);
    in_range_q_s = ({1'b0, addr_q} < DEPTH_EXT);
    idx_d_s      = addr_d[IDX_W-1:0];
    idx_q_s      = addr_q[IDX_W-1:0];
    mem_we_s     = (state_q == S_ACK) && op_wr_q && in_range_q_s;
  end

  // Output and watchdog next values. Each one follows the state being entered,
  // so the registered outputs line up with that state.
  always_comb begin
    rd_ack_d  = (state_d == S_ACK) && !op_wr_d;
    wr_ack_d  = (state_d == S_ACK) && op_wr_d;
    ref_ack_d = (state_d == S_REFRESH) && (rcnt_d == REF_LAST);
    busy_d    = (state_d != S_IDLE);
    if (ref_ack_q) begin
      tmr_d = {TMR_W{1'b0}};
    end else if (tmr_q == TMR_LIMIT) begin
      tmr_d = tmr_q;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
    missed_d = missed_q | (tmr_d == TMR_LIMIT);
  end

  // Control and output registers. Reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_wr_q   <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= 16'h0000;
      lat_q     <= {LAT_W{1'b0}};
      rcnt_q    <= {RCNT_W{1'b0}};
      tmr_q     <= {TMR_W{1'b0}};
      missed_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      ref_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lat_q     <= lat_d;
      rcnt_q    <= rcnt_d;
      tmr_q     <= tmr_d;
      missed_q  <= missed_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      ref_ack_q <= ref_ack_d;
      busy_q    <= busy_d;
    end
  end

  // Registered read port. It loads on entry to a read ACK and holds otherwise.
  // Out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 16'h0000;
    end else if (rd_ack_d) begin
      rdata_q <= in_range_d_s ? mem_q[idx_d_s] : 16'h0000;
    end else begin
      rdata_q <= rdata_q;
    end
  end

  // Single write port. The captured word commits at the end of the write ACK
  // cycle. Out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_q_s] <= wdata_q;
    end
  end

  assign readAcknowledge    = rd_ack_q;
  assign readData           = rdata_q;
  assign writeAcknowledge   = wr_ack_q;
  assign refreshAcknowledge = ref_ack_q;
  assign busy               = busy_q;
  assign refreshMissed      = missed_q;

endmodule

// File: tb/tb_row_memory_responder.sv
// tb_row_memory_responder
// Randomized bench with scoreboard checking for row_memory_responder.
// Stimulus tasks push expected acknowledges into a queue, and a negedge
// monitor pops and compares them. Expected read data comes from an
// associative-array memory model.
module tb_row_memory_responder;

  localparam int ADDR_W  = 24;
  localparam int DEPTH   = 32768;
  localparam int ACK_LAT = 2;
  localparam int REF_CYC = 8;
  localparam int REF_LIM = 1040;
  localparam int TIMEOUT = 200;

  localparam logic [1:0] K_RD  = 2'd0;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_REF = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read = 1'b0;
  logic [ADDR_W-1:0] readAddress = '0;
  logic              readAcknowledge;
  logic [15:0]       readData;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] writeAddress = '0;
  logic [15:0]       writeData = 16'h0000;
  logic              writeAcknowledge;
  logic              refresh = 1'b0;
  logic              refreshAcknowledge;
  logic              busy;
  logic              refreshMissed;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [15:0] model [int];
  logic [15:0] last_rd = 16'h0000;

  row_memory_responder #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ACK_LATENCY(ACK_LAT),
    .REFRESH_CYCLES(REF_CYC), .REFRESH_LIMIT(REF_LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .read(read), .readAddress(readAddress),
    .readAcknowledge(readAcknowledge), .readData(readData),
    .write(write), .writeAddress(writeAddress), .writeData(writeData),
    .writeAcknowledge(writeAcknowledge),
    .refresh(refresh), .refreshAcknowledge(refreshAcknowledge),
    .busy(busy), .refreshMissed(refreshMissed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] exp_read(input int a);
    if (a >= DEPTH) return 16'h0000;
    else if (model.exists(a)) return model[a];
    else return 16'h0000;
  endfunction

  task automatic push_exp(input logic [1:0] k, input logic [15:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_pop(input logic [1:0] k);
    exp_t e;
    check("busy_on_ack", {31'd0, busy}, 32'd1);
    if (exp_q.size() == 0) begin
      fail_now($sformatf("unexpected_ack kind %0d with nothing pending", k));
    end else begin
      e = exp_q.pop_front();
      check("ack_order", {30'd0, k}, {30'd0, e.kind});
      if (k == K_RD) begin
        check("read_data", {16'd0, readData}, {16'd0, e.data});
        last_rd = e.data;
      end else if (k == K_WR) begin
        check("read_data_hold", {16'd0, readData}, {16'd0, last_rd});
      end
    end
  endtask

  // Scoreboard monitor: sample acknowledges on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (readAcknowledge)    mon_pop(K_RD);
      if (writeAcknowledge)   mon_pop(K_WR);
      if (refreshAcknowledge) mon_pop(K_REF);
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdack"},  {31'd0, readAcknowledge},    32'd0);
    check({tag, "_wrack"},  {31'd0, writeAcknowledge},   32'd0);
    check({tag, "_refack"}, {31'd0, refreshAcknowledge}, 32'd0);
    check({tag, "_rdata"},  {16'd0, readData},           32'd0);
    check({tag, "_busy"},   {31'd0, busy},               32'd0);
    check({tag, "_missed"}, {31'd0, refreshMissed},      32'd0);
  endtask

  // Burst of n words at consecutive addresses, held as a level request.
  task automatic do_burst(input bit is_wr, input int base, input int n,
                          input bit rnd, input logic [15:0] dbase);
    int st;
    int last;
    bit got;
    logic [15:0] d;
    last = 0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (is_wr) begin
        d = rnd ? 16'($urandom) : (dbase + 16'(i));
        write = 1'b1;
        writeAddress = ADDR_W'(base + i);
        writeData = d;
        if (base + i < DEPTH) model[base + i] = d;
        push_exp(K_WR, d);
      end else begin
        read = 1'b1;
        readAddress = ADDR_W'(base + i);
        push_exp(K_RD, exp_read(base + i));
      end
      st = cyc;
      got = 1'b0;
      for (int t = 0; t < TIMEOUT && !got; t++) begin
        @(posedge clk); #1;
        got = is_wr ? writeAcknowledge : readAcknowledge;
      end
      if (!got) begin
        fail_now("ack_timeout");
        write = 1'b0;
        read = 1'b0;
        return;
      end
      if (i == 0) check("first_ack_latency", cyc - st, ACK_LAT + 1);
      else        check("word_period", cyc - last, ACK_LAT + 2);
      last = cyc;
    end
    write = 1'b0;
    read = 1'b0;
  endtask

  task automatic do_refresh();
    int st;
    bit got;
    @(posedge clk); #1;
    refresh = 1'b1;
    push_exp(K_REF, 16'h0000);
    st = cyc;
    got = 1'b0;
    for (int t = 0; t < TIMEOUT && !got; t++) begin
      @(posedge clk); #1;
      got = refreshAcknowledge;
    end
    refresh = 1'b0;
    if (!got) fail_now("refresh_timeout");
    else check("refresh_latency", cyc - st, REF_CYC);
  endtask

  // Watchdog so that the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int seen;
    logic [15:0] d;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Refresh starvation: the flag rises exactly at cycle REF_LIM.
    repeat (REF_LIM - 1) @(posedge clk);
    #1;
    check("missed_before_limit", {31'd0, refreshMissed}, 32'd0);
    @(posedge clk); #1;
    check("missed_at_limit", {31'd0, refreshMissed}, 32'd1);

    // Prefill a known region with random data.
    do_burst(1'b1, 0, 128, 1'b1, 16'h0000);

    // 40 words written at 0x40 and read back.
    do_burst(1'b1, 32'h40, 40, 1'b0, 16'hA000);
    do_burst(1'b0, 32'h40, 40, 1'b0, 16'h0000);

    // Boundary addresses.
    do_burst(1'b1, DEPTH, 1, 1'b0, 16'h1234);
    do_burst(1'b0, 0, 1, 1'b0, 16'h0000);
    do_burst(1'b0, DEPTH, 1, 1'b0, 16'h0000);
    do_burst(1'b1, DEPTH - 1, 1, 1'b0, 16'h5A5A);
    do_burst(1'b0, DEPTH - 1, 1, 1'b0, 16'h0000);
    do_burst(1'b0, (1 << ADDR_W) - 1, 1, 1'b0, 16'h0000);

    // All three requests in one IDLE cycle: refresh, then write, then read.
    @(posedge clk); #1;
    d = 16'($urandom);
    refresh = 1'b1;
    write = 1'b1; writeAddress = ADDR_W'(10); writeData = d;
    read = 1'b1;  readAddress = ADDR_W'(20);
    push_exp(K_REF, 16'h0000);
    push_exp(K_WR, d);
    model[10] = d;
    push_exp(K_RD, exp_read(20));
    st = cyc;
    seen = 0;
    for (int t = 0; t < TIMEOUT && seen < 3; t++) begin
      @(posedge clk); #1;
      if (refreshAcknowledge) begin
        check("simul_refresh_latency", cyc - st, REF_CYC);
        refresh = 1'b0;
        seen++;
      end
      if (writeAcknowledge) begin write = 1'b0; seen++; end
      if (readAcknowledge)  begin read = 1'b0;  seen++; end
    end
    if (seen < 3) fail_now("simul_timeout");
    refresh = 1'b0; write = 1'b0; read = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      int op;
      int n;
      int base;
      op = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) base = DEPTH + int'($urandom_range(0, 200));
      else base = int'($urandom_range(0, 124));
      if (op == 2) do_refresh();
      else do_burst(op == 1, base, n, 1'b1, 16'h0000);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    check("missed_sticky", {31'd0, refreshMissed}, 32'd1);

    // Reset in the WAIT of a write: no ack and memory left unchanged.
    @(posedge clk); #1;
    write = 1'b1; writeAddress = ADDR_W'(5); writeData = 16'hBEEF;
    @(posedge clk); #1;
    check("busy_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check_outputs_zero("midwait_reset");
    write = 1'b0;
    read = 1'b1; readAddress = ADDR_W'(5);
    push_exp(K_RD, exp_read(5));
    @(negedge clk);
    rst = 1'b1;
    st = cyc;
    seen = 0;
    for (int t = 0; t < TIMEOUT && seen == 0; t++) begin
      @(posedge clk); #1;
      if (readAcknowledge) seen = 1;
    end
    read = 1'b0;
    if (seen == 0) fail_now("post_reset_read_timeout");
    else check("post_reset_first_accept", cyc - st, ACK_LAT + 1);
    check("missed_cleared", {31'd0, refreshMissed}, 32'd0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
